// File: rtl/wb_stage_buffered.sv
// Buffered write-back stage: selects the result, queues it, and drains
// it to the register-file write port while exposing queued writes.
module wb_stage_buffered #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int DEPTH   = 4,
  parameter int R0_ZERO = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2*DATA_W+REG_AW+2:0] pipeline_reg_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       rf_write_grant,
  output logic                       reg_write_en,
  output logic [REG_AW-1:0]          reg_write_dest,
  output logic [DATA_W-1:0]          reg_write_data,
  output logic [REG_AW-1:0]          wb_op_dest,
  input  logic [REG_AW-1:0]          hz_addr,
  output logic                       hz_hit,
  output logic [DATA_W-1:0]          hz_data,
  output logic [$clog2(DEPTH):0]     wb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = 2*DATA_W + REG_AW + 3;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] mem_rd;
  logic              wb_en;
  logic [REG_AW-1:0] wb_dest;
  logic [1:0]        wb_sel;

  assign alu_res = pipeline_reg_in[IW-1 -: DATA_W];
  assign mem_rd  = pipeline_reg_in[IW-DATA_W-1 -: DATA_W];
  assign wb_en   = pipeline_reg_in[REG_AW+2];
  assign wb_dest = pipeline_reg_in[REG_AW+1:2];
  assign wb_sel  = pipeline_reg_in[1:0];

  entry_t          ent_q [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] byte_sx;
  logic [DATA_W-1:0] byte_zx;
  logic              not_empty;
  logic              accept;
  logic              keep;
  logic              push;
  logic              pop;
  entry_t            head;

  always_comb begin
    byte_sx      = {DATA_W{mem_rd[7]}};
    byte_sx[7:0] = mem_rd[7:0];
    byte_zx      = '0;
    byte_zx[7:0] = mem_rd[7:0];
  end

  always_comb begin
    wb_data = alu_res;
    unique case (wb_sel)
      2'b00: wb_data = alu_res;
      2'b01: wb_data = mem_rd;
      2'b10: wb_data = byte_sx;
      2'b11: wb_data = byte_zx;
      default: wb_data = alu_res;
    endcase
  end

  assign not_empty = count != '0;
  assign pop       = not_empty & rf_write_grant;
  assign in_ready  = (count < CW'(DEPTH)) | pop;
  assign accept    = in_valid & in_ready;

  // Disabled writes and (optionally) r0 writes are consumed here.
  assign keep = wb_en & ~((R0_ZERO != 0) && (wb_dest == '0));
  assign push = accept & keep;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) ent_q[wr_ptr] <= '{dest: wb_dest, data: wb_data};
  end

  assign head           = ent_q[rd_ptr];
  assign reg_write_en   = pop;
  assign reg_write_dest = not_empty ? head.dest : '0;
  assign reg_write_data = not_empty ? head.data : '0;
  assign wb_op_dest     = not_empty ? head.dest : '0;
  assign wb_count       = count;

  // Scan oldest to youngest so the last match seen wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    hz_hit  = 1'b0;
    hz_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (ent_q[idx].dest == hz_addr)) begin
        hz_hit  = 1'b1;
        hz_data = ent_q[idx].data;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_buffered.sv
// Self-checking bench for wb_stage_buffered: directed vectors,
// multi-cycle corner sequences and a random run against a queue model.
module tb_wb_stage_buffered;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int D  = 4;
  localparam int IW = 2*DW + AW + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] pipeline_reg_in;
  logic          in_valid;
  logic          v0;
  logic          rf_write_grant;
  logic [AW-1:0] hz_addr;

  logic          in_ready, reg_write_en, hz_hit;
  logic [AW-1:0] reg_write_dest, wb_op_dest;
  logic [DW-1:0] reg_write_data, hz_data;
  logic [2:0]    wb_count;

  logic          rdy0, we0, hh0;
  logic [AW-1:0] wd0, opd0;
  logic [DW-1:0] data0, hd0;
  logic [2:0]    cnt0;

  always #5 clk = ~clk;

  wb_stage_buffered #(.DATA_W(DW), .REG_AW(AW), .DEPTH(D), .R0_ZERO(1)) dut (
    .clk(clk), .rst(rst), .pipeline_reg_in(pipeline_reg_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .rf_write_grant(rf_write_grant), .reg_write_en(reg_write_en),
    .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
    .wb_op_dest(wb_op_dest), .hz_addr(hz_addr), .hz_hit(hz_hit),
    .hz_data(hz_data), .wb_count(wb_count)
  );

  wb_stage_buffered #(.DATA_W(DW), .REG_AW(AW), .DEPTH(D), .R0_ZERO(0)) dut0 (
    .clk(clk), .rst(rst), .pipeline_reg_in(pipeline_reg_in),
    .in_valid(v0), .in_ready(rdy0),
    .rf_write_grant(rf_write_grant), .reg_write_en(we0),
    .reg_write_dest(wd0), .reg_write_data(data0),
    .wb_op_dest(opd0), .hz_addr(hz_addr), .hz_hit(hh0),
    .hz_data(hd0), .wb_count(cnt0)
  );

  typedef struct {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    logic [DW-1:0] alu;
    logic [DW-1:0] mem;
    logic [AW-1:0] dest;
    logic [1:0]    sel;
    logic [DW-1:0] exp;
  } vec_t;

  ent_t          q[$];
  logic [AW-1:0] commits[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic          samp_ready;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [DW-1:0] alu,
    input logic [DW-1:0] mem, input logic en, input logic [AW-1:0] dest,
    input logic [1:0] sel);
    return {alu, mem, en, dest, sel};
  endfunction

  function automatic logic [DW-1:0] ref_sel(input logic [DW-1:0] alu,
    input logic [DW-1:0] mem, input logic [1:0] sel);
    int b;
    b = int'(mem) % 256;
    case (sel)
      2'd0: return alu;
      2'd1: return mem;
      2'd2: return (b >= 128) ? DW'(b + 65280) : DW'(b);
      default: return DW'(b);
    endcase
  endfunction

  // One clock: drive, check against the queue model, then advance it.
  task automatic step(input logic v, input logic [DW-1:0] alu,
    input logic [DW-1:0] mem, input logic en, input logic [AW-1:0] dest,
    input logic [1:0] sel, input logic g, input logic [AW-1:0] ha);
    int n;
    logic ep, er, eh;
    logic [DW-1:0] ehd;
    in_valid        = v;
    pipeline_reg_in = mk(alu, mem, en, dest, sel);
    rf_write_grant  = g;
    hz_addr         = ha;
    #2;
    n  = q.size();
    ep = (n != 0) && g;
    er = (n < D) || ep;
    eh = 1'b0;
    ehd = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (q[i].dest == ha) begin
        eh  = 1'b1;
        ehd = q[i].data;
        break;
      end
    end
    chk("in_ready", in_ready, er);
    chk("reg_write_en", reg_write_en, ep);
    chk("reg_write_dest", reg_write_dest, n != 0 ? q[0].dest : 0);
    chk("reg_write_data", reg_write_data, n != 0 ? q[0].data : 0);
    chk("wb_op_dest", wb_op_dest, n != 0 ? q[0].dest : 0);
    chk("wb_count", wb_count, n);
    chk("hz_hit", hz_hit, eh);
    chk("hz_data", hz_data, ehd);
    chk("pop_when_empty", reg_write_en && wb_count == 0, 0);
    chk("count_bound", wb_count > D, 0);
    samp_ready = in_ready;
    if (reg_write_en === 1'b1) commits.push_back(reg_write_dest);
    @(posedge clk);
    if (ep) void'(q.pop_front());
    if (v && er && en && dest != 0)
      q.push_back('{dest: dest, data: ref_sel(alu, mem, sel)});
    @(negedge clk);
  endtask

  task automatic idle(input logic g, input logic [AW-1:0] ha);
    step(1'b0, '0, '0, 1'b0, '0, 2'd0, g, ha);
  endtask

  vec_t vt[5];

  initial begin
    vt[0] = '{alu: 16'h1234, mem: 16'h0000, dest: 3'd3, sel: 2'd0, exp: 16'h1234};
    vt[1] = '{alu: 16'h0000, mem: 16'h00F0, dest: 3'd4, sel: 2'd2, exp: 16'hFFF0};
    vt[2] = '{alu: 16'h0000, mem: 16'h00F0, dest: 3'd5, sel: 2'd3, exp: 16'h00F0};
    vt[3] = '{alu: 16'h0000, mem: 16'hBEEF, dest: 3'd6, sel: 2'd1, exp: 16'hBEEF};
    vt[4] = '{alu: 16'hAAAA, mem: 16'h017F, dest: 3'd7, sel: 2'd2, exp: 16'h007F};

    rst = 1'b0;
    in_valid = 1'b0;
    v0 = 1'b0;
    rf_write_grant = 1'b1;
    hz_addr = '0;
    pipeline_reg_in = '0;
    #1;
    chk("rst_count", wb_count, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_we", reg_write_en, 0);
    chk("rst_hz_hit", hz_hit, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single-word commits and data select modes
    for (int i = 0; i < 5; i++) begin
      step(1'b1, vt[i].alu, vt[i].mem, 1'b1, vt[i].dest, vt[i].sel, 1'b1, '0);
      in_valid = 1'b0;
      rf_write_grant = 1'b1;
      #1;
      chk("vec_we", reg_write_en, 1);
      chk("vec_dest", reg_write_dest, vt[i].dest);
      chk("vec_data", reg_write_data, vt[i].exp);
      idle(1'b1, '0);
      #1 chk("vec_count_after", wb_count, 0);
    end

    // Backpressure: fifth word stalls until the port is granted
    for (int d = 1; d <= 4; d++)
      step(1'b1, DW'(16'h0100 + d), '0, 1'b1, AW'(d), 2'd0, 1'b0, '0);
    in_valid = 1'b1;
    pipeline_reg_in = mk(16'h0105, '0, 1'b1, 3'd5, 2'd0);
    rf_write_grant = 1'b0;
    #1;
    chk("full_ready", in_ready, 0);
    chk("full_count", wb_count, 4);
    step(1'b1, 16'h0105, '0, 1'b1, 3'd5, 2'd0, 1'b0, '0);
    commits.delete();
    step(1'b1, 16'h0105, '0, 1'b1, 3'd5, 2'd0, 1'b1, '0);
    chk("full_pop_push_ready", samp_ready, 1);
    for (int k = 0; k < 6; k++) idle(1'b1, '0);
    chk("order_len", commits.size(), 5);
    for (int k = 0; k < 5 && k < commits.size(); k++)
      chk("order_dest", commits[k], k + 1);

    // Streaming through a full FIFO with the port granted
    for (int d = 1; d <= 4; d++)
      step(1'b1, DW'(16'h0200 + d), '0, 1'b1, AW'(d), 2'd0, 1'b0, '0);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, DW'(16'h0300 + k), '0, 1'b1, AW'(k % 7 + 1), 2'd0, 1'b1, '0);
      chk("stream_ready", samp_ready, 1);
    end
    for (int k = 0; k < 5; k++) idle(1'b1, '0);

    // Hazard lookup picks the youngest match
    step(1'b1, 16'h0011, '0, 1'b1, 3'd2, 2'd0, 1'b0, '0);
    step(1'b1, 16'h0022, '0, 1'b1, 3'd5, 2'd0, 1'b0, '0);
    step(1'b1, 16'h0033, '0, 1'b1, 3'd2, 2'd0, 1'b0, '0);
    in_valid = 1'b0;
    hz_addr = 3'd2;
    #1;
    chk("hz2_hit", hz_hit, 1);
    chk("hz2_data", hz_data, 16'h0033);
    hz_addr = 3'd4;
    #1;
    chk("hz4_hit", hz_hit, 0);
    chk("hz4_data", hz_data, 0);
    idle(1'b0, 3'd5);
    for (int k = 0; k < 4; k++) idle(1'b1, 3'd2);

    // Dropped words
    commits.delete();
    step(1'b1, 16'h7777, '0, 1'b0, 3'd6, 2'd0, 1'b1, '0);
    chk("drop_en_ready", samp_ready, 1);
    step(1'b1, 16'h8888, '0, 1'b1, 3'd0, 2'd0, 1'b1, '0);
    chk("drop_r0_ready", samp_ready, 1);
    idle(1'b1, '0);
    chk("drop_no_commit", commits.size(), 0);
    chk("drop_count", wb_count, 0);

    // r0 writes commit when R0_ZERO=0
    in_valid = 1'b0;
    v0 = 1'b1;
    pipeline_reg_in = mk(16'h5A5A, '0, 1'b1, 3'd0, 2'd0);
    rf_write_grant = 1'b1;
    #2;
    chk("r0_ready", rdy0, 1);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    #2;
    chk("r0_we", we0, 1);
    chk("r0_dest", wd0, 0);
    chk("r0_data", data0, 16'h5A5A);
    @(negedge clk);

    // Asynchronous reset while entries are queued
    step(1'b1, 16'h0AAA, '0, 1'b1, 3'd1, 2'd0, 1'b0, '0);
    step(1'b1, 16'h0BBB, '0, 1'b1, 3'd2, 2'd0, 1'b0, '0);
    step(1'b1, 16'h0CCC, '0, 1'b1, 3'd3, 2'd0, 1'b0, '0);
    in_valid = 1'b0;
    hz_addr = 3'd1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", wb_count, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_hz", hz_hit, 0);
    q.delete();
    in_valid = 1'b1;
    pipeline_reg_in = mk(16'h0DDD, '0, 1'b1, 3'd4, 2'd0);
    rf_write_grant = 1'b1;
    @(posedge clk);
    #1 chk("arst_ignore_in", wb_count, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    commits.delete();
    for (int k = 0; k < 4; k++) idle(1'b1, 3'd1);
    chk("arst_no_commit", commits.size(), 0);

    // Random traffic against the queue model
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 1) == 1, DW'($urandom), DW'($urandom),
           $urandom_range(0, 4) != 0, AW'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), $urandom_range(0, 9) < 6,
           AW'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
